// File: rtl/gate_sweep_checker.sv
// Stimulus/check stage for a two-input gate: sweeps in1/in2 over all four vectors,
// waits SETTLE_CYC cycles, samples dut_out against TRUTH and accumulates errors.
module gate_sweep_checker #(
   parameter logic [3:0]  TRUTH      = 4'b1110,
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned PASSES     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dut_out,
   output logic       in1,
   output logic       in2,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [3:0] fail_vec
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] SWEEP_LAST  = 8'(PASSES - 1);

   state_t     r_state;
   logic [1:0] r_idx;
   logic [7:0] r_settle;
   logic [7:0] r_sweep;
   logic [7:0] r_err;
   logic [3:0] r_fail;
   logic       r_in1;
   logic       r_in2;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;

   logic       w_mismatch;
   logic [7:0] w_err_next;
   logic       w_start_ok;

   assign w_mismatch = (dut_out != TRUTH[r_idx]);
   assign w_err_next = (w_mismatch && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;
   // done/pass register one cycle after entering DONE; a restart is only taken once done is visible
   assign w_start_ok = start && ((r_state == S_IDLE) || ((r_state == S_DONE) && r_done));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_settle <= '0;
         r_sweep  <= '0;
         r_err    <= '0;
         r_fail   <= '0;
         r_in1    <= 1'b0;
         r_in2    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (r_state == S_DONE) begin
                  r_done <= 1'b1;
                  r_pass <= (r_err == '0);
               end
               if (w_start_ok) begin
                  r_state <= S_DRIVE;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
                  r_err   <= '0;
                  r_fail  <= '0;
                  r_idx   <= '0;
                  r_sweep <= '0;
               end
            end
            S_DRIVE: begin
               r_in1    <= r_idx[1];
               r_in2    <= r_idx[0];
               r_settle <= SETTLE_LOAD;
               r_state  <= S_SETTLE;
            end
            S_SETTLE: begin
               if (r_settle == '0) begin
                  r_state <= S_SAMPLE;
               end else begin
                  r_settle <= r_settle - 8'd1;
               end
            end
            S_SAMPLE: begin
               r_err <= w_err_next;
               if (w_mismatch) begin
                  r_fail[r_idx] <= 1'b1;
               end
               r_idx   <= r_idx + 2'd1;
               r_state <= S_DRIVE;
               if (r_idx == 2'd3) begin
                  r_sweep <= r_sweep + 8'd1;
                  if (r_sweep == SWEEP_LAST) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in1       = r_in1;
   assign in2       = r_in2;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_count = r_err;
   assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomised self-checking bench for gate_sweep_checker: two instances (OR defaults and
// a saturating multi-pass setup) driven by table-based gate models.
module tb_gate_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       a_start, b_start;
   logic [3:0] a_tbl, b_tbl;
   logic       a_out, b_out;
   logic       a_in1, a_in2, a_busy, a_done, a_pass;
   logic       b_in1, b_in2, b_busy, b_done, b_pass;
   logic [7:0] a_err, b_err;
   logic [3:0] a_fail, b_fail;
   logic [1:0] a_vec, b_vec;

   int n_checks = 0;
   int n_errors = 0;

   assign a_vec = {a_in1, a_in2};
   assign b_vec = {b_in1, b_in2};
   assign a_out = a_tbl[a_vec];
   assign b_out = b_tbl[b_vec];

   gate_sweep_checker #(.TRUTH(4'b1110), .SETTLE_CYC(2), .PASSES(1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .dut_out(a_out),
      .in1(a_in1), .in2(a_in2), .busy(a_busy), .done(a_done), .pass(a_pass),
      .err_count(a_err), .fail_vec(a_fail)
   );

   gate_sweep_checker #(.TRUTH(4'b1000), .SETTLE_CYC(1), .PASSES(100)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .dut_out(b_out),
      .in1(b_in1), .in2(b_in2), .busy(b_busy), .done(b_done), .pass(b_pass),
      .err_count(b_err), .fail_vec(b_fail)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: every sweep mismatches exactly where the gate's table differs from TRUTH
   function automatic int exp_errs(input logic [3:0] tbl, input logic [3:0] truth, input int passes);
      int e;
      e = passes * $countones(tbl ^ truth);
      return (e > 255) ? 255 : e;
   endfunction

   // One run on an instance; per = cycles per vector, truth/passes describe the instance.
   task automatic run(input bit inst_b, input logic [3:0] tbl, input bit hold, input string tag);
      int per, passes, total, k;
      logic [3:0] truth;
      bit seen;
      per    = inst_b ? 3 : 4;
      passes = inst_b ? 100 : 1;
      truth  = inst_b ? 4'b1000 : 4'b1110;
      total  = passes * 4 * per;
      if (inst_b) b_tbl = tbl; else a_tbl = tbl;
      @(negedge clk);
      if (inst_b) b_start = 1'b1; else a_start = 1'b1;
      seen = 1'b0;
      for (int w = 0; w < 6; w++) begin
         @(posedge clk); #1;
         if ((inst_b ? b_busy : a_busy) === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "/accept"}, 32'(seen), 32'd1);
      if (!hold) begin
         if (inst_b) b_start = 1'b0; else a_start = 1'b0;
      end
      k = 0;
      while (k < total + 40) begin
         @(posedge clk); #1;
         k++;
         if (k <= total) begin
            check({tag, "/vec"}, 32'(inst_b ? b_vec : a_vec), 32'(((k - 1) / per) % 4));
            check({tag, "/busy"}, 32'(inst_b ? b_busy : a_busy), 32'(k < total));
         end
         if ((inst_b ? b_done : a_done) === 1'b1) break;
      end
      check({tag, "/latency"}, 32'(k), 32'(total + 1));
      check({tag, "/err"}, 32'(inst_b ? b_err : a_err), 32'(exp_errs(tbl, truth, passes)));
      check({tag, "/fail"}, 32'(inst_b ? b_fail : a_fail), 32'(tbl ^ truth));
      check({tag, "/pass"}, 32'(inst_b ? b_pass : a_pass), 32'(exp_errs(tbl, truth, passes) == 0));
      check({tag, "/vec_hold"}, 32'(inst_b ? b_vec : a_vec), 32'd3);
   endtask

   task automatic check_a_zero(input string tag);
      check({tag, "/a_outs"}, {a_in1, a_in2, a_busy, a_done, a_pass, a_err, a_fail}, '0);
   endtask

   initial begin
      logic [3:0] t;
      int done_hi;
      rst_n   = 1'b0;
      a_start = 1'b0;
      b_start = 1'b0;
      a_tbl   = 4'b1110;
      b_tbl   = 4'b1000;
      repeat (3) @(posedge clk);
      #1;
      check_a_zero("reset");
      check("reset/b_outs", {b_in1, b_in2, b_busy, b_done, b_pass, b_err, b_fail}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      run(1'b0, 4'b1110, 1'b0, "or_gate");
      run(1'b0, 4'b0000, 1'b0, "tie0");
      run(1'b0, 4'b0001, 1'b0, "nor_gate");
      run(1'b1, 4'b1111, 1'b0, "sat_tie1");

      // Reset during SETTLE of vector 2 with one error already logged
      a_tbl = 4'b1111;
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("midrst/pre_vec", 32'(a_vec), 32'd2);
      check("midrst/pre_err", 32'(a_err), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_a_zero("midrst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      done_hi = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (a_done) done_hi++;
      end
      check("midrst/no_done", 32'(done_hi), 32'd0);
      run(1'b0, 4'b1110, 1'b0, "post_rst");

      // start held through the run, then re-arms from DONE
      run(1'b0, 4'b1110, 1'b1, "hold1");
      run(1'b0, 4'b1110, 1'b0, "hold2");

      for (int r = 0; r < 6; r++) begin
         t = 4'($urandom);
         run(1'b0, t, 1'b0, "rand_a");
      end
      t = 4'($urandom);
      run(1'b1, t, 1'b0, "rand_b");
      run(1'b1, 4'b1000, 1'b0, "b_clean");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
